// File: rtl/acp_burst_arbiter_pkg.sv
// Shared definitions for the ADC-to-Ethernet burst arbiter: FSM states,
// channel identifiers and default burst geometry.
package acp_burst_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_READ,
    ST_DRAIN,
    ST_GAP
  } state_t;

  localparam logic CH_ADC1 = 1'b0;
  localparam logic CH_ADC2 = 1'b1;

  localparam int BURST_LEN_DEF  = 256;
  localparam int GAP_CYCLES_DEF = 12;

endpackage

// File: rtl/acp_rr_select.sv
// Combinational channel choice: a channel is eligible once its FIFO holds a
// full burst; ties go to the channel that was not served last.
module acp_rr_select
  import acp_burst_arbiter_pkg::*;
#(
  parameter int CNT_W     = 9,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic [CNT_W-1:0] rd_count_1,
  input  logic [CNT_W-1:0] rd_count_2,
  input  logic             last_ch,
  output logic             eligible,
  output logic             pick
);

  // One extra bit so a BURST_LEN equal to 2**CNT_W is never eligible.
  localparam logic [CNT_W:0] THRESH = (CNT_W+1)'(BURST_LEN);

  logic [1:0][CNT_W-1:0] count;
  logic [1:0]            elig;

  assign count = {rd_count_2, rd_count_1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign elig[gi] = ({1'b0, count[gi]} >= THRESH);
    end
  endgenerate

  always_comb begin
    eligible = |elig;
    pick     = CH_ADC1;
    if (elig[0] && elig[1]) begin
      pick = (last_ch == CH_ADC1) ? CH_ADC2 : CH_ADC1;
    end else if (elig[1]) begin
      pick = CH_ADC2;
    end
  end

endmodule

// File: rtl/acp_burst_arbiter.sv
// Moves fixed-length bursts from two ADC FIFOs to the Ethernet packet
// builder, alternating fairly between channels with an idle gap per burst.
module acp_burst_arbiter
  import acp_burst_arbiter_pkg::*;
#(
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W      = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] rd_count_1,
  input  logic [CNT_W-1:0] rd_count_2,
  input  logic [15:0]      dout_1,
  input  logic [15:0]      dout_2,
  input  logic             pkt_ready,
  output logic             rdreq_1,
  output logic             rdreq_2,
  output logic [15:0]      data_out,
  output logic             data_valid,
  output logic             burst_start,
  output logic             burst_done,
  output logic             burst_ch,
  output logic [15:0]      burst_seq
);

  localparam int WORD_W = $clog2(BURST_LEN + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  logic [1:0]        rst_sync_reg;
  logic              rst_int_n;
  state_t            state_reg, state_next;
  logic [WORD_W-1:0] word_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              ch_reg, last_ch_reg, enable_d_reg;
  logic [1:0][15:0]  seq_reg, seq_next;
  logic              data_valid_reg, burst_start_reg, burst_done_reg;
  logic              eligible, pick;
  logic              reading, last_word, gap_last, enable_rise;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= '0;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  assign reading     = (state_reg == ST_READ);
  assign last_word   = reading && (word_cnt_reg == WORD_LAST);
  assign gap_last    = (state_reg == ST_GAP) && (gap_cnt_reg == GAP_LAST);
  assign enable_rise = enable && !enable_d_reg;

  acp_rr_select #(
    .CNT_W     (CNT_W),
    .BURST_LEN (BURST_LEN)
  ) u_rr_select (
    .rd_count_1 (rd_count_1),
    .rd_count_2 (rd_count_2),
    .last_ch    (last_ch_reg),
    .eligible   (eligible),
    .pick       (pick)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (enable && pkt_ready) state_next = ST_SELECT;
      ST_SELECT: state_next = eligible ? ST_READ : ST_IDLE;
      ST_READ:   if (last_word) state_next = ST_DRAIN;
      ST_DRAIN:  state_next = ST_GAP;
      ST_GAP:    if (gap_last) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_seq
      assign seq_next[gi] = enable_rise ? 16'h0000 :
                            (burst_done_reg && (ch_reg == 1'(gi))) ? seq_reg[gi] + 16'd1 :
                            seq_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      word_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      ch_reg          <= CH_ADC1;
      last_ch_reg     <= CH_ADC2;
      enable_d_reg    <= 1'b0;
      seq_reg         <= '0;
      data_valid_reg  <= 1'b0;
      burst_start_reg <= 1'b0;
      burst_done_reg  <= 1'b0;
    end else begin
      enable_d_reg    <= enable;
      word_cnt_reg    <= reading ? word_cnt_reg + WORD_W'(1) : '0;
      gap_cnt_reg     <= (state_reg == ST_GAP) ? gap_cnt_reg + GAP_W'(1) : '0;
      data_valid_reg  <= reading;
      burst_start_reg <= reading && (word_cnt_reg == '0);
      burst_done_reg  <= last_word;
      seq_reg         <= seq_next;
      if (state_reg == ST_SELECT && eligible) ch_reg <= pick;
      if (enable_rise)         last_ch_reg <= CH_ADC2;
      else if (burst_done_reg) last_ch_reg <= ch_reg;
    end
  end

  // FIFO data lands one cycle after rdreq, aligned with data_valid_reg.
  assign rdreq_1     = reading && (ch_reg == CH_ADC1);
  assign rdreq_2     = reading && (ch_reg == CH_ADC2);
  assign data_valid  = data_valid_reg;
  assign data_out    = data_valid_reg ? ((ch_reg == CH_ADC2) ? dout_2 : dout_1) : 16'h0000;
  assign burst_start = burst_start_reg;
  assign burst_done  = burst_done_reg;
  assign burst_ch    = ch_reg;
  assign burst_seq   = seq_reg[ch_reg];

endmodule

// File: tb/tb_acp_burst_arbiter.sv
// Directed bench for acp_burst_arbiter: single channel, round-robin ties,
// insufficient data, mid-burst enable drop, async reset and sequence wrap.
module tb_acp_burst_arbiter;

  localparam int BL  = 256;
  localparam int GAP = 12;
  localparam int CW  = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          pkt_ready = 1'b0;
  logic [CW-1:0] rd_count_1 = '0;
  logic [CW-1:0] rd_count_2 = '0;
  logic [15:0]   dout_1 = 16'h1000;
  logic [15:0]   dout_2 = 16'h2000;
  logic          rdreq_1, rdreq_2, data_valid, burst_start, burst_done, burst_ch;
  logic [15:0]   data_out, burst_seq;

  int n_checks = 0;
  int n_fail   = 0;
  int waited;

  always #5 clk = ~clk;

  acp_burst_arbiter #(
    .BURST_LEN  (BL),
    .GAP_CYCLES (GAP),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rd_count_1  (rd_count_1),
    .rd_count_2  (rd_count_2),
    .dout_1      (dout_1),
    .dout_2      (dout_2),
    .pkt_ready   (pkt_ready),
    .rdreq_1     (rdreq_1),
    .rdreq_2     (rdreq_2),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .burst_start (burst_start),
    .burst_done  (burst_done),
    .burst_ch    (burst_ch),
    .burst_seq   (burst_seq)
  );

  // Non-FWFT FIFO model: each read returns an incrementing word a cycle later.
  always @(posedge clk) begin
    if (rdreq_1) dout_1 <= dout_1 + 16'd1;
    if (rdreq_2) dout_2 <= dout_2 + 16'd1;
  end

  always @(negedge clk) begin
    n_checks++;
    assert (!(rdreq_1 && rdreq_2)) else begin
      n_fail++;
      $error("FAIL rdreq_mutex: observed rdreq_1=%0b rdreq_2=%0b expected not both", rdreq_1, rdreq_2);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_window(input string tag, input int cycles);
    int n_rd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rdreq_1 || rdreq_2 || data_valid) n_rd++;
    end
    check(tag, n_rd, 0);
  endtask

  task automatic observe_burst(input string tag, input logic exp_ch, input logic [15:0] exp_seq,
                               input int drop_at, output int wait_cycles);
    int n_rd = 0, n_wrong = 0, n_dv = 0, n_dly = 0, n_start = 0, n_done = 0;
    int done_idx = -1, n_data = 0, n_chg = 0;
    logic prev_rd = 1'b0, start_first = 1'b0, found = 1'b0, ch_at = 1'b0;
    logic [15:0] seq_at = 16'h0, first_word = 16'h0, last_data = 16'h0;
    wait_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rdreq_1 || rdreq_2) begin
        found = 1'b1;
        break;
      end
      wait_cycles++;
    end
    check({tag, "_found"}, found, 1);
    if (!found) return;
    for (int c = 0; c < BL + 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) enable = 1'b0;
      if (exp_ch ? rdreq_2 : rdreq_1) n_rd++;
      if (exp_ch ? rdreq_1 : rdreq_2) n_wrong++;
      if (data_valid !== prev_rd) n_dly++;
      if (burst_start) n_start++;
      if (burst_done) n_done++;
      if (data_valid) begin
        if (n_dv == 0) begin
          start_first = burst_start;
          seq_at      = burst_seq;
          ch_at       = burst_ch;
          first_word  = data_out;
        end else begin
          if (data_out !== last_data + 16'd1) n_data++;
          if (burst_ch !== ch_at) n_chg++;
        end
        if (burst_done) done_idx = n_dv;
        last_data = data_out;
        n_dv++;
      end
      prev_rd = rdreq_1 || rdreq_2;
    end
    check({tag, "_rd_cycles"}, n_rd, BL);
    check({tag, "_wrong_rdreq"}, n_wrong, 0);
    check({tag, "_dv_cycles"}, n_dv, BL);
    check({tag, "_dv_delay"}, n_dly, 0);
    check({tag, "_start_first"}, start_first, 1);
    check({tag, "_start_count"}, n_start, 1);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_done_last"}, done_idx, BL - 1);
    check({tag, "_ch"}, ch_at, exp_ch);
    check({tag, "_ch_stable"}, n_chg, 0);
    check({tag, "_seq"}, seq_at, exp_seq);
    check({tag, "_src"}, first_word[15:12], exp_ch ? 4'h2 : 4'h1);
    check({tag, "_data"}, n_data, 0);
  endtask

  initial begin
    // Reset with stimulus already demanding a burst.
    rd_count_1 = 9'd300;
    rd_count_2 = 9'd0;
    enable     = 1'b1;
    pkt_ready  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_rdreq_1", rdreq_1, 0);
    check("rst_rdreq_2", rdreq_2, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_burst_start", burst_start, 0);
    check("rst_burst_done", burst_done, 0);
    check("rst_burst_ch", burst_ch, 0);
    check("rst_burst_seq", burst_seq, 0);
    check("rst_data_out", data_out, 0);
    rst_n = 1'b1;

    // Single channel: two back-to-back ch0 bursts, 11 quiet samples after
    // the observation window (DRAIN + 12 GAP + IDLE + SELECT = 15 idle cycles).
    observe_burst("t1_b0", 1'b0, 16'd0, -1, waited);
    observe_burst("t1_b1", 1'b0, 16'd1, -1, waited);
    check("t1_gap_len", waited, 11);
    enable = 1'b0;
    idle_window("t1_idle", 60);
    check("t1_seq_hold", burst_seq, 2);

    // Tie: round-robin starting at ch0, sequence numbers cleared by enable rise.
    rd_count_1 = 9'd511;
    rd_count_2 = 9'd511;
    enable = 1'b1;
    observe_burst("t2_b0", 1'b0, 16'd0, -1, waited);
    observe_burst("t2_b1", 1'b1, 16'd0, -1, waited);
    observe_burst("t2_b2", 1'b0, 16'd1, -1, waited);
    observe_burst("t2_b3", 1'b1, 16'd1, -1, waited);
    enable = 1'b0;
    idle_window("t2_idle", 40);

    // Insufficient data, then ch1 reaches exactly BURST_LEN.
    rd_count_1 = 9'd255;
    rd_count_2 = 9'd255;
    enable = 1'b1;
    idle_window("t3_no_data", 300);
    rd_count_2 = 9'd256;
    observe_burst("t3_ch1", 1'b1, 16'd0, -1, waited);
    enable = 1'b0;
    idle_window("t3_idle", 40);

    // Enable drops at word 100: burst completes, then stays idle.
    rd_count_1 = 9'd300;
    rd_count_2 = 9'd0;
    enable = 1'b1;
    observe_burst("t4", 1'b0, 16'd0, 100, waited);
    idle_window("t4_idle", 100);
    check("t4_seq_after", burst_seq, 1);
    check("t4_ch_after", burst_ch, 0);

    // Async reset at word 50 of a ch1 burst.
    rd_count_1 = 9'd300;
    rd_count_2 = 9'd300;
    enable = 1'b1;
    observe_burst("t5_pre", 1'b0, 16'd0, -1, waited);
    begin
      logic got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (rdreq_2) begin
          got = 1'b1;
          break;
        end
      end
      check("t5_ch1_found", got, 1);
    end
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_rdreq_2", rdreq_2, 0);
    check("t5_rst_rdreq_1", rdreq_1, 0);
    check("t5_rst_dv", data_valid, 0);
    check("t5_rst_data_out", data_out, 0);
    check("t5_rst_ch", burst_ch, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    observe_burst("t5_post", 1'b0, 16'd0, -1, waited);
    enable = 1'b0;
    idle_window("t5_idle", 40);

    // Sequence wrap on ch1 from a preloaded 0xFFFF.
    rd_count_1 = 9'd0;
    rd_count_2 = 9'd0;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    force dut.seq_reg = 32'hFFFF_0000;
    @(negedge clk);
    release dut.seq_reg;
    rd_count_2 = 9'd300;
    observe_burst("t6_ffff", 1'b1, 16'hFFFF, -1, waited);
    observe_burst("t6_wrap", 1'b1, 16'h0000, -1, waited);
    enable = 1'b0;
    idle_window("t6_idle", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
